// File: rtl/rsa_modexp_if.sv
// Request/response bundle for the modular exponentiator.
// The requester drives start and the operands; the exponentiator returns
// status and the result.
interface rsa_modexp_if #(
    parameter int K = 64
);
    logic         start;
    logic [K-1:0] base;
    logic [K-1:0] exponent;
    logic [K-1:0] modulus;
    logic         busy;
    logic         done;
    logic         error;
    logic [K-1:0] result;

    modport master (
        output start, base, exponent, modulus,
        input  busy, done, error, result
    );

    modport slave (
        input  start, base, exponent, modulus,
        output busy, done, error, result
    );
endinterface

// File: rtl/rsa_modexp.sv
// Iterative right-to-left modular exponentiator: result = base^exponent mod modulus.
// A single bit-serial interleaved modular multiplier (one operand bit per cycle,
// K cycles per product) is shared by the base reduction, multiply and square steps.
module rsa_modexp #(
    parameter int WIDTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    rsa_modexp_if.slave bus
);
    localparam int K  = 2 * WIDTH;
    localparam int CW = $clog2(K);

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        CHECK,
        MUL,
        SQR,
        FINISH
    } state_t;

    state_t         state_q, state_d;
    logic [K-1:0]   base_q;
    logic [K-1:0]   mod_q;
    logic [K-1:0]   ecnt_q;
    logic [K-1:0]   res_q;
    logic [K-1:0]   pow_q;
    logic [K-1:0]   acc_q;
    logic [CW-1:0]  bit_q;
    logic           err_q;
    logic [K-1:0]   result_q;
    logic           error_q;

    logic           accept;
    logic           bad_mod;
    logic           last_bit;
    logic [K-1:0]   mul_a;
    logic [K-1:0]   mul_b;
    logic           mul_bit;
    logic [K:0]     n_ext;
    logic [K:0]     t_dbl;
    logic [K:0]     t_red;
    logic [K:0]     t_add;
    logic [K-1:0]   acc_next;

    assign accept   = (state_q == IDLE) && bus.start;
    assign bad_mod  = (bus.modulus < K'(2));
    assign last_bit = (bit_q == '0);

    // Select the multiplier operands for the current phase; a is always < n.
    always_comb begin
        mul_a = res_q;
        mul_b = pow_q;
        case (state_q)
            REDUCE:  begin mul_a = K'(1); mul_b = base_q; end
            MUL:     begin mul_a = res_q; mul_b = pow_q;  end
            SQR:     begin mul_a = pow_q; mul_b = pow_q;  end
            default: begin mul_a = res_q; mul_b = pow_q;  end
        endcase
    end

    assign mul_bit = mul_b[bit_q];

    // One step of the interleaved multiply: double, reduce, conditionally add, reduce.
    // Both reductions need only one subtraction because every intermediate stays below 2n.
    always_comb begin
        n_ext    = {1'b0, mod_q};
        t_dbl    = {acc_q, 1'b0};
        t_red    = (t_dbl >= n_ext) ? (t_dbl - n_ext) : t_dbl;
        t_add    = mul_bit ? (t_red + {1'b0, mul_a}) : t_red;
        acc_next = (t_add >= n_ext) ? K'(t_add - n_ext) : K'(t_add);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A bad modulus passes through CHECK with a zero exponent
    // counter so it reaches FINISH one cycle after acceptance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = bad_mod ? CHECK : REDUCE;
            REDUCE:  if (last_bit) state_d = CHECK;
            CHECK: begin
                if (ecnt_q == '0)     state_d = FINISH;
                else if (ecnt_q[0])   state_d = MUL;
                else                  state_d = SQR;
            end
            MUL:     if (last_bit) state_d = SQR;
            SQR:     if (last_bit) state_d = CHECK;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, multiplier iteration and write-back of products.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q   <= '0;
            mod_q    <= '0;
            ecnt_q   <= '0;
            res_q    <= '0;
            pow_q    <= '0;
            acc_q    <= '0;
            bit_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        base_q <= bus.base;
                        mod_q  <= bus.modulus;
                        ecnt_q <= bad_mod ? '0 : bus.exponent;
                        err_q  <= bad_mod;
                        acc_q  <= '0;
                        bit_q  <= CW'(K - 1);
                    end
                end
                REDUCE, MUL, SQR: begin
                    if (last_bit) begin
                        acc_q <= '0;
                        bit_q <= CW'(K - 1);
                        if (state_q == REDUCE) begin
                            pow_q <= acc_next;
                            res_q <= K'(1);
                        end else if (state_q == MUL) begin
                            res_q <= acc_next;
                        end else begin
                            pow_q  <= acc_next;
                            ecnt_q <= ecnt_q >> 1;
                        end
                    end else begin
                        acc_q <= acc_next;
                        bit_q <= bit_q - CW'(1);
                    end
                end
                CHECK: begin
                    // Outputs update only on the edge that enters FINISH.
                    if (ecnt_q == '0) begin
                        result_q <= err_q ? '0 : res_q;
                        error_q  <= err_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state_q != IDLE) && (state_q != FINISH);
    assign bus.done   = (state_q == FINISH);
    assign bus.error  = error_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_rsa_modexp.sv
// Self-checking bench for rsa_modexp at WIDTH=4 (K=8) against a plain-arithmetic model.
module tb_rsa_modexp;
    localparam int WIDTH = 4;
    localparam int K     = 2 * WIDTH;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rsa_modexp_if #(.K(K)) bus ();

    rsa_modexp #(.WIDTH(WIDTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result: repeated multiplication with a remainder after each step.
    function automatic int ref_modexp(input int b, input int e, input int n);
        int r;
        if (n < 2) return 0;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * (b % n)) % n;
        return r;
    endfunction

    // Expected number of edges from acceptance to the edge before done is seen.
    function automatic int ref_latency(input int e, input int n);
        int m;
        int total;
        if (n < 2) return 1;
        total = K + 1;
        m = -1;
        for (int i = 0; i < K; i++) if ((e >> i) & 1) m = i;
        for (int i = 0; i <= m; i++) total += 1 + K * (1 + ((e >> i) & 1));
        return total;
    endfunction

    // Issue one request and wait for done; ncyc = -1 if done never arrives.
    task automatic run_req(input logic [K-1:0] b, input logic [K-1:0] e, input logic [K-1:0] n,
                           output logic [K-1:0] res, output logic err, output int ncyc,
                           output logic busy0, output logic busy_done);
        @(negedge clk);
        bus.start = 1'b1; bus.base = b; bus.exponent = e; bus.modulus = n;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.base = K'($urandom); bus.exponent = K'($urandom); bus.modulus = K'($urandom);
        busy0 = bus.busy;
        ncyc = -1;
        for (int k = 0; k < 3000; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.done) begin ncyc = k; break; end
        end
        res = bus.result; err = bus.error; busy_done = bus.busy;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.base = '0; bus.exponent = '0; bus.modulus = '0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (bus.busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        if (bus.done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
        if (bus.error !== 1'b0)  begin errors++; $display("FAIL reset_error got=%b want=0", bus.error); end
        if (bus.result !== '0)   begin errors++; $display("FAIL reset_result got=%0d want=0", bus.result); end
        rst_n = 1'b1;
        $display("reset: busy=%b done=%b error=%b result=%0d", bus.busy, bus.done, bus.error, bus.result);
    endtask

    task automatic test_encrypt_decrypt;
        logic [K-1:0] r1, r2;
        logic e1, e2, b0, bd;
        int n1, n2;
        run_req(8'd4, 8'd3, 8'd33, r1, e1, n1, b0, bd);
        $display("encrypt: base=4 exp=3 mod=33 result=%0d error=%b N=%0d", r1, e1, n1);
        checks += 5;
        if (r1 !== 8'(ref_modexp(4, 3, 33))) begin errors++; $display("FAIL enc_result got=%0d want=%0d", r1, ref_modexp(4, 3, 33)); end
        if (n1 != ref_latency(3, 33)) begin errors++; $display("FAIL enc_latency got=%0d want=%0d", n1, ref_latency(3, 33)); end
        if (e1 !== 1'b0) begin errors++; $display("FAIL enc_error got=%b want=0", e1); end
        if (b0 !== 1'b1) begin errors++; $display("FAIL enc_busy got=%b want=1", b0); end
        if (bd !== 1'b0) begin errors++; $display("FAIL enc_busy_at_done got=%b want=0", bd); end
        run_req(r1, 8'd7, 8'd33, r2, e2, n2, b0, bd);
        $display("decrypt: base=%0d exp=7 mod=33 result=%0d error=%b N=%0d", r1, r2, e2, n2);
        checks += 3;
        if (r2 !== 8'd4) begin errors++; $display("FAIL dec_roundtrip got=%0d want=4", r2); end
        if (n2 != ref_latency(7, 33)) begin errors++; $display("FAIL dec_latency got=%0d want=%0d", n2, ref_latency(7, 33)); end
        if (e2 !== 1'b0) begin errors++; $display("FAIL dec_error got=%b want=0", e2); end
    endtask

    task automatic test_reduction;
        int tb_b[3] = '{37, 37, 66};
        int tb_e[3] = '{3, 0, 5};
        logic [K-1:0] r;
        logic e, b0, bd;
        int n;
        for (int i = 0; i < 3; i++) begin
            run_req(8'(tb_b[i]), 8'(tb_e[i]), 8'd33, r, e, n, b0, bd);
            $display("reduce: base=%0d exp=%0d mod=33 result=%0d N=%0d", tb_b[i], tb_e[i], r, n);
            checks += 2;
            if (r !== 8'(ref_modexp(tb_b[i], tb_e[i], 33))) begin
                errors++; $display("FAIL reduce_result[%0d] got=%0d want=%0d", i, r, ref_modexp(tb_b[i], tb_e[i], 33));
            end
            if (n != ref_latency(tb_e[i], 33)) begin
                errors++; $display("FAIL reduce_latency[%0d] got=%0d want=%0d", i, n, ref_latency(tb_e[i], 33));
            end
        end
    endtask

    task automatic test_error;
        logic [K-1:0] r;
        logic e, b0, bd;
        int n;
        run_req(8'd4, 8'd3, 8'd1, r, e, n, b0, bd);
        $display("error: mod=1 result=%0d error=%b N=%0d", r, e, n);
        checks += 3;
        if (e !== 1'b1) begin errors++; $display("FAIL err_flag got=%b want=1", e); end
        if (r !== '0)   begin errors++; $display("FAIL err_result got=%0d want=0", r); end
        if (n != 1)     begin errors++; $display("FAIL err_latency got=%0d want=1", n); end
        run_req(8'd5, 8'd2, 8'd33, r, e, n, b0, bd);
        $display("error_clear: base=5 exp=2 mod=33 result=%0d error=%b", r, e);
        checks += 2;
        if (e !== 1'b0) begin errors++; $display("FAIL err_clear got=%b want=0", e); end
        if (r !== 8'(ref_modexp(5, 2, 33))) begin errors++; $display("FAIL err_clear_result got=%0d want=%0d", r, ref_modexp(5, 2, 33)); end
    endtask

    task automatic test_ignore_start;
        int n;
        n = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.base = 8'd4; bus.exponent = 8'd3; bus.modulus = 8'd33;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 20) begin bus.start = 1'b1; bus.base = 8'd9; bus.exponent = 8'd11; bus.modulus = 8'd35; end
            if (k == 21) bus.start = 1'b0;
            if (bus.done) begin n = k; break; end
        end
        $display("ignore_start: result=%0d N=%0d", bus.result, n);
        checks += 2;
        if (bus.result !== 8'(ref_modexp(4, 3, 33))) begin errors++; $display("FAIL ignore_result got=%0d want=%0d", bus.result, ref_modexp(4, 3, 33)); end
        if (n != ref_latency(3, 33)) begin errors++; $display("FAIL ignore_latency got=%0d want=%0d", n, ref_latency(3, 33)); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_not_queued busy=%b want=0", bus.busy); end
    endtask

    task automatic test_back_to_back;
        int k1, k2;
        logic [K-1:0] r1, r2;
        k1 = -1; k2 = -1; r1 = '0; r2 = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.base = 8'd4; bus.exponent = 8'd3; bus.modulus = 8'd33;
        @(posedge clk);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (k == 1) begin bus.base = 8'd31; bus.exponent = 8'd7; end
            if (bus.done) begin
                if (k1 < 0) begin k1 = k; r1 = bus.result; end
                else begin k2 = k; r2 = bus.result; bus.start = 1'b0; break; end
            end
        end
        $display("back_to_back: r1=%0d at %0d r2=%0d at %0d", r1, k1, r2, k2);
        checks += 4;
        if (r1 !== 8'(ref_modexp(4, 3, 33)))  begin errors++; $display("FAIL b2b_result1 got=%0d want=%0d", r1, ref_modexp(4, 3, 33)); end
        if (r2 !== 8'(ref_modexp(31, 7, 33))) begin errors++; $display("FAIL b2b_result2 got=%0d want=%0d", r2, ref_modexp(31, 7, 33)); end
        if (k1 != ref_latency(3, 33)) begin errors++; $display("FAIL b2b_latency1 got=%0d want=%0d", k1, ref_latency(3, 33)); end
        if (k2 - k1 != ref_latency(7, 33) + 2) begin errors++; $display("FAIL b2b_gap got=%0d want=%0d", k2 - k1, ref_latency(7, 33) + 2); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_stop busy=%b want=0", bus.busy); end
    endtask

    task automatic test_reset_mid;
        logic seen_done;
        logic [K-1:0] r;
        logic e, b0, bd;
        int n;
        seen_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.base = 8'd7; bus.exponent = 8'd3; bus.modulus = 8'd33;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got=%b want=1", bus.busy); end
        rst_n = 1'b0;
        #1;
        $display("reset_mid: busy=%b done=%b error=%b result=%0d", bus.busy, bus.done, bus.error, bus.result);
        checks += 3;
        if (bus.busy !== 1'b0)  begin errors++; $display("FAIL midreset_busy got=%b want=0", bus.busy); end
        if (bus.done !== 1'b0)  begin errors++; $display("FAIL midreset_done got=%b want=0", bus.done); end
        if (bus.result !== '0)  begin errors++; $display("FAIL midreset_result got=%0d want=0", bus.result); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin errors++; $display("FAIL midreset_no_done got=%b want=0", seen_done); end
        run_req(8'd4, 8'd3, 8'd33, r, e, n, b0, bd);
        $display("after_reset: result=%0d N=%0d", r, n);
        checks += 2;
        if (r !== 8'(ref_modexp(4, 3, 33))) begin errors++; $display("FAIL midreset_recover got=%0d want=%0d", r, ref_modexp(4, 3, 33)); end
        if (n != ref_latency(3, 33)) begin errors++; $display("FAIL midreset_latency got=%0d want=%0d", n, ref_latency(3, 33)); end
    endtask

    task automatic test_random;
        logic [K-1:0] r;
        logic e, b0, bd;
        int n, vb, ve, vn;
        for (int i = 0; i < 20; i++) begin
            vb = int'($urandom_range(0, 255));
            ve = int'($urandom_range(0, 255));
            vn = (i % 7 == 6) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 255));
            run_req(8'(vb), 8'(ve), 8'(vn), r, e, n, b0, bd);
            $display("random[%0d]: base=%0d exp=%0d mod=%0d result=%0d error=%b N=%0d", i, vb, ve, vn, r, e, n);
            checks += 3;
            if (r !== 8'(ref_modexp(vb, ve, vn))) begin errors++; $display("FAIL rand_result[%0d] got=%0d want=%0d", i, r, ref_modexp(vb, ve, vn)); end
            if (e !== (vn < 2)) begin errors++; $display("FAIL rand_error[%0d] got=%b want=%b", i, e, vn < 2); end
            if (n != ref_latency(ve, vn)) begin errors++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, n, ref_latency(ve, vn)); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_encrypt_decrypt();
        test_reduction();
        test_error();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
